mac_tile_mw: RTL and testbench
==============================

MAC_TILE_MW -- requirements
Module: mac_tile_mw

Interface
REQ-001 SHALL have parameter BW, default 4, meaning activation/weight width in bits.
REQ-002 SHALL have parameter PSUM_BW, default 16, meaning partial-sum width in bits.
REQ-003 SHALL have parameter NW, default 4, meaning the number of stored weight contexts (NW>=1).
REQ-004 SHALL have parameter GCNT_BW, default 16, meaning the width of the gated-cycle counter.
REQ-005 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port in_w  input  BW  activation (execute) or weight (load) from west.
REQ-008 SHALL have port inst_w  input  3  instruction from west: [0] load, [1] execute, [2] reload-arm.
REQ-009 SHALL have port ctx_w  input  max(1,clog2(NW))  weight-context select from west.
REQ-010 SHALL have port in_n  input  PSUM_BW  partial sum from north.
REQ-011 SHALL have port out_e  output  BW  registered in_w forwarded east.
REQ-012 SHALL have port inst_e  output  3  registered instruction forwarded east.
REQ-013 SHALL have port ctx_e  output  max(1,clog2(NW))  registered ctx_w forwarded east.
REQ-014 SHALL have port out_s  output  PSUM_BW  registered partial sum to south.
REQ-015 SHALL have port out_s_valid  output  1  high the cycle after an execute cycle.
REQ-016 SHALL have port gate_cnt  output  GCNT_BW  count of zero-gated execute cycles.

Function
REQ-017 SHALL hold NW weight registers (wbank[0..NW-1]) and a load counter wcnt (0..NW).
REQ-018 SHALL, when inst_w[0]=1, inst_w[2]=0 and wcnt<NW, capture in_w into wbank[wcnt] and increment wcnt.
REQ-019 SHALL drive inst_e[0] <= inst_w[0] & (wcnt==NW), so load is forwarded east only after the tile's banks are full.
REQ-020 SHALL drive inst_e[1] <= inst_w[1], inst_e[2] <= inst_w[2], ctx_e <= ctx_w every cycle.
REQ-021 SHALL load out_e <= in_w when inst_w[0] or inst_w[1] is 1; otherwise hold out_e.
REQ-022 SHALL, on inst_w[2]=1, set wcnt to 0 and capture no weight that cycle (reload beats load); wbank contents are retained until overwritten.
REQ-023 SHALL treat in_w as unsigned, weights as two's-complement signed, and psums as signed PSUM_BW, wrapping modulo 2^PSUM_BW.
REQ-024 SHALL, on inst_w[1]=1 with in_w!=0 and ctx_w<NW, set out_s <= in_n + in_w*wbank[ctx_w].
REQ-025 SHALL, on inst_w[1]=1 with in_w==0, set out_s <= in_n, skip the multiply and increment gate_cnt, saturating at all-ones.
REQ-026 SHALL, on inst_w[1]=1 with ctx_w>=NW (non-power-of-2 NW), set out_s <= in_n without incrementing gate_cnt.
REQ-027 SHALL hold out_s when inst_w[1]=0, and set out_s_valid <= inst_w[1] every cycle.
REQ-028 SHALL, when load and execute are both asserted in one cycle, execute with the pre-write wbank value.
REQ-029 SHALL have 1-cycle latency from every input to its corresponding output.

Reset
REQ-030 SHALL, on reset, clear out_e, inst_e, ctx_e, out_s, out_s_valid, gate_cnt, wcnt and all wbank entries to 0; reset overrides all instructions.

Verification
REQ-031 SHALL be verified by test: reset, load 3,-2,7,-8 over 4 cycles -> inst_e[0]=0 throughout; 5th load in_w=5 -> inst_e[0]=1, out_e=5, banks unchanged.
REQ-032 SHALL be verified by test: execute in_w=9, ctx_w=1, in_n=100 -> next cycle out_s=82, out_s_valid=1.
REQ-033 SHALL be verified by test: execute in_w=0, in_n=0x1234 -> out_s=0x1234, gate_cnt 0->1.
REQ-034 SHALL be verified by test: execute in_w=15, ctx_w=2, in_n=0x7FFF -> out_s=0x8068 (wrap).
REQ-035 SHALL be verified by test: inst_w=3'b101 with in_w=4 -> wcnt=0, no capture; next 4 loads overwrite bank0..3.
REQ-036 SHALL be verified by test: reset after 2 loads -> all outputs 0, next load writes wbank[0].

Source files
------------

// File: rtl/mac_tile_mw.sv
// Weight-stationary MAC tile with NW stored weight contexts and zero-gating.
// Ports: clk/reset, west in_w/inst_w/ctx_w, north in_n, east out_e/inst_e/ctx_e, south out_s/out_s_valid, gate_cnt.
module mac_tile_mw #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int NW      = 4,
    parameter int GCNT_BW = 16,
    localparam int CTX_BW = (NW > 1) ? $clog2(NW) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BW-1:0]      in_w,
    input  logic [2:0]         inst_w,
    input  logic [CTX_BW-1:0]  ctx_w,
    input  logic [PSUM_BW-1:0] in_n,
    output logic [BW-1:0]      out_e,
    output logic [2:0]         inst_e,
    output logic [CTX_BW-1:0]  ctx_e,
    output logic [PSUM_BW-1:0] out_s,
    output logic               out_s_valid,
    output logic [GCNT_BW-1:0] gate_cnt
);

    localparam int WCNT_BW = $clog2(NW + 1);

    logic signed [BW-1:0] wbank_q [NW];
    logic signed [BW-1:0] wbank_d [NW];
    logic [WCNT_BW-1:0]   wcnt_q, wcnt_d;
    logic [BW-1:0]        out_e_q, out_e_d;
    logic [2:0]           inst_e_q, inst_e_d;
    logic [CTX_BW-1:0]    ctx_e_q;
    logic [PSUM_BW-1:0]   out_s_q, out_s_d;
    logic                 valid_q;
    logic [GCNT_BW-1:0]   gate_q, gate_d;

    logic signed [BW-1:0]      wsel;
    logic                      ctx_ok;
    logic                      full;
    logic signed [PSUM_BW-1:0] prod;

    always_comb begin
        wsel   = '0;
        ctx_ok = 1'b0;
        for (int i = 0; i < NW; i++) begin
            if (ctx_w == CTX_BW'(i)) begin
                wsel   = wbank_q[i];
                ctx_ok = 1'b1;
            end
        end

        full = (wcnt_q == WCNT_BW'(NW));

        // Weight capture; reload-arm rewinds the pointer and wins over load.
        wbank_d = wbank_q;
        wcnt_d  = wcnt_q;
        if (inst_w[2]) begin
            wcnt_d = '0;
        end else if (inst_w[0] && !full) begin
            for (int i = 0; i < NW; i++) begin
                if (wcnt_q == WCNT_BW'(i)) begin
                    wbank_d[i] = in_w;
                end
            end
            wcnt_d = wcnt_q + WCNT_BW'(1);
        end

        // Activation is unsigned: zero-extend before the signed multiply.
        prod = PSUM_BW'($signed({1'b0, in_w})) * PSUM_BW'(wsel);

        out_s_d = out_s_q;
        gate_d  = gate_q;
        if (inst_w[1]) begin
            if (in_w == '0) begin
                out_s_d = in_n;
                if (gate_q != '1) begin
                    gate_d = gate_q + GCNT_BW'(1);
                end
            end else if (ctx_ok) begin
                out_s_d = in_n + prod;
            end else begin
                out_s_d = in_n;
            end
        end

        out_e_d  = (inst_w[0] | inst_w[1]) ? in_w : out_e_q;
        inst_e_d = {inst_w[2], inst_w[1], inst_w[0] & full};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NW; i++) begin
                wbank_q[i] <= '0;
            end
            wcnt_q   <= '0;
            out_e_q  <= '0;
            inst_e_q <= '0;
            ctx_e_q  <= '0;
            out_s_q  <= '0;
            valid_q  <= 1'b0;
            gate_q   <= '0;
        end else begin
            for (int i = 0; i < NW; i++) begin
                wbank_q[i] <= wbank_d[i];
            end
            wcnt_q   <= wcnt_d;
            out_e_q  <= out_e_d;
            inst_e_q <= inst_e_d;
            ctx_e_q  <= ctx_w;
            out_s_q  <= out_s_d;
            valid_q  <= inst_w[1];
            gate_q   <= gate_d;
        end
    end

    assign out_e       = out_e_q;
    assign inst_e      = inst_e_q;
    assign ctx_e       = ctx_e_q;
    assign out_s       = out_s_q;
    assign out_s_valid = valid_q;
    assign gate_cnt    = gate_q;

endmodule

// File: tb/tb_mac_tile_mw.sv
// Testbench for mac_tile_mw: table of vectors plus scoreboard for out_s.
// Small gate counter width so saturation is reachable.
module tb_mac_tile_mw;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_w;
    logic [2:0]  inst_w;
    logic [1:0]  ctx_w;
    logic [15:0] in_n;
    logic [3:0]  out_e;
    logic [2:0]  inst_e;
    logic [1:0]  ctx_e;
    logic [15:0] out_s;
    logic        out_s_valid;
    logic [3:0]  gate_cnt;

    mac_tile_mw #(
        .BW(4), .PSUM_BW(16), .NW(4), .GCNT_BW(4)
    ) dut (
        .clk(clk), .reset(reset),
        .in_w(in_w), .inst_w(inst_w), .ctx_w(ctx_w), .in_n(in_n),
        .out_e(out_e), .inst_e(inst_e), .ctx_e(ctx_e),
        .out_s(out_s), .out_s_valid(out_s_valid), .gate_cnt(gate_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  inst;
        logic [3:0]  inw;
        logic [1:0]  ctx;
        logic [15:0] inn;
        logic [3:0]  e_oute;
        logic [2:0]  e_inste;
        logic [3:0]  e_gate;
        logic [15:0] e_outs;
    } vec_t;

    int checks = 0;
    int failures = 0;
    logic [15:0] sb[$];
    logic [15:0] held;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, a, e);
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        in_w = '0; inst_w = '0; ctx_w = '0; in_n = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        held = '0;
        chk({tag, ".out_e"}, out_e, 0);
        chk({tag, ".inst_e"}, inst_e, 0);
        chk({tag, ".ctx_e"}, ctx_e, 0);
        chk({tag, ".out_s"}, out_s, 0);
        chk({tag, ".valid"}, out_s_valid, 0);
        chk({tag, ".gate"}, gate_cnt, 0);
    endtask

    task automatic step(input vec_t v, input string tag);
        logic [15:0] exp;
        inst_w = v.inst; in_w = v.inw; ctx_w = v.ctx; in_n = v.inn;
        if (v.inst[1]) sb.push_back(v.e_outs);
        @(posedge clk);
        #1;
        chk({tag, ".out_e"}, out_e, v.e_oute);
        chk({tag, ".inst_e"}, inst_e, v.e_inste);
        chk({tag, ".ctx_e"}, ctx_e, v.ctx);
        chk({tag, ".gate"}, gate_cnt, v.e_gate);
        chk({tag, ".valid"}, out_s_valid, v.inst[1]);
        if (out_s_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s.sb unexpected valid out_s=%h", tag, out_s);
            end else begin
                exp = sb.pop_front();
                chk({tag, ".out_s"}, out_s, exp);
                held = exp;
            end
        end else begin
            chk({tag, ".out_s_hold"}, out_s, held);
        end
    endtask

    vec_t tbl[21];

    initial begin
        //          inst    inw    ctx   inn       oute   inste   gate  outs
        tbl[0]  = '{3'b001, 4'd3,  2'd0, 16'd0,    4'd3,  3'b000, 4'd0, 16'h0000};
        tbl[1]  = '{3'b001, 4'hE,  2'd0, 16'd0,    4'hE,  3'b000, 4'd0, 16'h0000};
        tbl[2]  = '{3'b001, 4'd7,  2'd0, 16'd0,    4'd7,  3'b000, 4'd0, 16'h0000};
        tbl[3]  = '{3'b001, 4'h8,  2'd0, 16'd0,    4'h8,  3'b000, 4'd0, 16'h0000};
        tbl[4]  = '{3'b001, 4'd5,  2'd0, 16'd0,    4'd5,  3'b001, 4'd0, 16'h0000};
        tbl[5]  = '{3'b010, 4'd9,  2'd1, 16'd100,  4'd9,  3'b010, 4'd0, 16'd82};
        tbl[6]  = '{3'b010, 4'd0,  2'd0, 16'h1234, 4'd0,  3'b010, 4'd1, 16'h1234};
        tbl[7]  = '{3'b010, 4'd15, 2'd2, 16'h7FFF, 4'hF,  3'b010, 4'd1, 16'h8068};
        tbl[8]  = '{3'b010, 4'd1,  2'd3, 16'd0,    4'd1,  3'b010, 4'd1, 16'hFFF8};
        tbl[9]  = '{3'b010, 4'd2,  2'd0, 16'd10,   4'd2,  3'b010, 4'd1, 16'd16};
        tbl[10] = '{3'b000, 4'd7,  2'd1, 16'd55,   4'd2,  3'b000, 4'd1, 16'h0000};
        tbl[11] = '{3'b101, 4'd4,  2'd0, 16'd0,    4'd4,  3'b101, 4'd1, 16'h0000};
        tbl[12] = '{3'b010, 4'd1,  2'd0, 16'd0,    4'd1,  3'b010, 4'd1, 16'd3};
        tbl[13] = '{3'b011, 4'd2,  2'd0, 16'd0,    4'd2,  3'b010, 4'd1, 16'd6};
        tbl[14] = '{3'b001, 4'd1,  2'd0, 16'd0,    4'd1,  3'b000, 4'd1, 16'h0000};
        tbl[15] = '{3'b001, 4'hF,  2'd0, 16'd0,    4'hF,  3'b000, 4'd1, 16'h0000};
        tbl[16] = '{3'b001, 4'd6,  2'd0, 16'd0,    4'd6,  3'b000, 4'd1, 16'h0000};
        tbl[17] = '{3'b010, 4'd1,  2'd0, 16'd0,    4'd1,  3'b010, 4'd1, 16'd2};
        tbl[18] = '{3'b010, 4'd3,  2'd1, 16'd0,    4'd3,  3'b010, 4'd1, 16'd3};
        tbl[19] = '{3'b010, 4'd3,  2'd2, 16'd0,    4'd3,  3'b010, 4'd1, 16'hFFFD};
        tbl[20] = '{3'b010, 4'd15, 2'd3, 16'd0,    4'hF,  3'b010, 4'd1, 16'h005A};

        do_reset("rst0");
        for (int i = 0; i < 21; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Reset mid-load clears banks and rewinds the load pointer.
        do_reset("rst1");
        step('{3'b001, 4'd9, 2'd0, 16'd0, 4'd9, 3'b000, 4'd0, 16'h0}, "pre_a");
        step('{3'b001, 4'd1, 2'd0, 16'd0, 4'd1, 3'b000, 4'd0, 16'h0}, "pre_b");
        do_reset("rst2");
        step('{3'b001, 4'd7, 2'd0, 16'd0, 4'd7, 3'b000, 4'd0, 16'h0}, "post_ld");
        step('{3'b010, 4'd1, 2'd0, 16'd0, 4'd1, 3'b010, 4'd0, 16'd7}, "post_b0");
        step('{3'b010, 4'd1, 2'd1, 16'd5, 4'd1, 3'b010, 4'd0, 16'd5}, "post_b1");

        // Gated-cycle counter saturates at all-ones.
        for (int k = 0; k < 20; k++) begin
            logic [3:0] eg;
            eg = (k + 1 > 15) ? 4'd15 : 4'(k + 1);
            step('{3'b010, 4'd0, 2'(k), 16'(k * 3), 4'd0, 3'b010, eg, 16'(k * 3)},
                 $sformatf("sat%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
